// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;

   // One pending register-file write.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester-side handshake plus the register-file write port and hazard mask.
interface regfile_wb_arbiter_if #(
   parameter int NREQ = 2
);
   import regfile_wb_pkg::*;

   logic [NREQ-1:0]                 req_valid;
   logic [NREQ-1:0][REG_ADDR_W-1:0] req_addr;
   logic [NREQ-1:0][REG_DATA_W-1:0] req_data;
   logic [NREQ-1:0]                 req_ready;
   logic                            we;
   logic [REG_ADDR_W-1:0]           wa;
   logic [REG_DATA_W-1:0]           wd;
   logic [NUM_REGS-1:0]             busy;

   // Requesters / testbench side.
   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, we, wa, wd, busy
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, we, wa, wd, busy
   );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Per-requester writeback FIFO. Slot valid bits double as the occupancy
// state and as the per-entry view used to build the pending-write mask.
module wb_fifo
   import regfile_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_push,
   input  wb_entry_t             i_din,
   output logic                  o_full,
   input  logic                  i_pop,
   output wb_entry_t             o_head,
   output logic                  o_empty,
   output logic [DEPTH-1:0]      o_vld,
   output wb_entry_t [DEPTH-1:0] o_mem
);

   localparam int PW = $clog2(DEPTH);

   wb_entry_t [DEPTH-1:0] r_mem;
   logic      [DEPTH-1:0] r_vld;
   logic      [PW-1:0]    r_wptr;
   logic      [PW-1:0]    r_rptr;
   logic                  w_do_push;
   logic                  w_do_pop;

   // Slots fill in order, so the write slot is occupied only when full and
   // the read slot is free only when empty.
   assign o_full    = r_vld[r_wptr];
   assign o_empty   = ~r_vld[r_rptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_head    = r_mem[r_rptr];
   assign o_vld     = r_vld;
   assign o_mem     = r_mem;

   // Occupancy and pointers; push and pop never target the same slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld  <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) begin
            r_vld[r_wptr] <= 1'b1;
            r_wptr        <= r_wptr + PW'(1);
         end
         if (w_do_pop) begin
            r_vld[r_rptr] <= 1'b0;
            r_rptr        <= r_rptr + PW'(1);
         end
      end
   end

   // Entry storage.
   // NOTE: payload is not reset; r_vld gates every use of it, so reset only the valid bits.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_din;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NREQ requesters: private
// FIFOs, a round-robin scheduler, a registered write stage and a
// pending-write mask for hazard detection.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int DEPTH = 2
) (
   input logic                 clk,
   input logic                 reset,
   regfile_wb_arbiter_if.slave bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic      [NREQ-1:0]     w_full;
   logic      [NREQ-1:0]     w_empty;
   logic      [NREQ-1:0]     w_pop;
   wb_entry_t                w_din  [NREQ];
   wb_entry_t                w_head [NREQ];
   logic      [DEPTH-1:0]    w_vld  [NREQ];
   wb_entry_t [DEPTH-1:0]    w_mem  [NREQ];

   logic                     w_gnt_vld;
   logic      [PW-1:0]       w_gnt_idx;
   logic      [PW-1:0]       w_rr_next;
   wb_entry_t                w_gnt_head;
   logic      [NUM_REGS-1:0] w_busy;

   logic      [PW-1:0]       r_rr_ptr;
   logic                     r_we;
   logic      [REG_ADDR_W-1:0] r_wa;
   logic      [REG_DATA_W-1:0] r_wd;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_din[gi].addr = bus.req_addr[gi];
      assign w_din[gi].data = bus.req_data[gi];

      wb_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .i_push  (bus.req_valid[gi]),
         .i_din   (w_din[gi]),
         .o_full  (w_full[gi]),
         .i_pop   (w_pop[gi]),
         .o_head  (w_head[gi]),
         .o_empty (w_empty[gi]),
         .o_vld   (w_vld[gi]),
         .o_mem   (w_mem[gi])
      );
   end

   // Ready reflects FIFO occupancy only; a same-cycle pop does not free a slot.
   assign bus.req_ready = ~w_full;

   // Round-robin search: first non-empty FIFO at or after r_rr_ptr.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      int              idx;
      logic [PW-1:0]   v_idx;
      idx       = 0;
      v_idx     = '0;
      w_gnt_vld = 1'b0;
      w_gnt_idx = r_rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         v_idx = PW'(idx);
         if (!w_gnt_vld && !w_empty[v_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = v_idx;
         end
      end
   end

   // Pop the granted head and compute the pointer that follows it.
   always_comb begin
      w_pop = '0;
      if (w_gnt_vld) w_pop[w_gnt_idx] = 1'b1;
      w_rr_next  = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
      w_gnt_head = w_head[w_gnt_idx];
   end

   // Write stage and scheduler pointer; r0 writes are consumed silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr <= '0;
         r_we     <= 1'b0;
         r_wa     <= '0;
         r_wd     <= '0;
      end else if (w_gnt_vld) begin
         r_rr_ptr <= w_rr_next;
         r_we     <= (w_gnt_head.addr != '0);
         r_wa     <= w_gnt_head.addr;
         r_wd     <= w_gnt_head.data;
      end else begin
         r_we     <= 1'b0;
      end
   end

   // Pending-write mask: every queued entry plus the live write stage.
   always_comb begin
      w_busy = '0;
      for (int i = 0; i < NREQ; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (w_vld[i][j]) w_busy[w_mem[i][j].addr] = 1'b1;
         end
      end
      if (r_we) w_busy[r_wa] = 1'b1;
      w_busy[0] = 1'b0;
   end

   assign bus.we   = r_we;
   assign bus.wa   = r_wa;
   assign bus.wd   = r_wd;
   assign bus.busy = w_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: stimulus queues the expected register-file writes in
// hand-computed grant order; a monitor pops and compares on every we pulse.
module tb_regfile_wb_arbiter;
   import regfile_wb_pkg::*;

   localparam int NREQ  = 2;
   localparam int DEPTH = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

   regfile_wb_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   wb_entry_t exp_q[$];

   logic [4:0]  s_addr [NREQ][8];
   logic [31:0] s_data [NREQ][8];
   int          s_cnt  [NREQ];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wb_entry_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every write-enable pulse must match the next expected write.
   initial begin
      wb_entry_t e;
      forever begin
         @(negedge clk);
         if (bus.we === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("spurious_we", 32'(bus.we), 32'h0);
            end else begin
               e = exp_q.pop_front();
               check("wa", 32'(bus.wa), 32'(e.addr));
               check("wd", bus.wd, e.data);
            end
         end
      end
   end

   // Drives the s_* streams with valid held until accepted. Reports how many
   // entries watch_req had accepted when its ready was first seen low.
   task automatic run_streams(input int watch_req, output int acc_at_low);
      int              idx [NREQ];
      logic [NREQ-1:0] rdy;
      logic            left;
      int              budget;
      acc_at_low = -1;
      budget     = 0;
      for (int r = 0; r < NREQ; r++) idx[r] = 0;
      left = 1'b1;
      while (left && budget < 100) begin
         for (int r = 0; r < NREQ; r++) begin
            if (idx[r] < s_cnt[r]) begin
               bus.req_valid[r] = 1'b1;
               bus.req_addr[r]  = s_addr[r][idx[r]];
               bus.req_data[r]  = s_data[r][idx[r]];
            end else begin
               bus.req_valid[r] = 1'b0;
            end
         end
         rdy = bus.req_ready;
         if (watch_req >= 0 && acc_at_low < 0 && !rdy[watch_req]) acc_at_low = idx[watch_req];
         @(posedge clk);
         for (int r = 0; r < NREQ; r++) if (bus.req_valid[r] && rdy[r]) idx[r]++;
         #1;
         budget++;
         left = 1'b0;
         for (int r = 0; r < NREQ; r++) if (idx[r] < s_cnt[r]) left = 1'b1;
      end
      bus.req_valid = '0;
      check("streams_done", 32'(left), 32'h0);
   endtask

   task automatic single_push(input int r, input logic [4:0] a, input logic [31:0] d);
      bus.req_valid    = '0;
      bus.req_valid[r] = 1'b1;
      bus.req_addr[r]  = a;
      bus.req_data[r]  = d;
      tick();
      bus.req_valid = '0;
   endtask

   initial begin
      int acc;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;

      // Reset held two cycles with requests active.
      reset            = 1'b1;
      bus.req_valid    = '1;
      bus.req_addr[0]  = 5'd7;
      bus.req_addr[1]  = 5'd8;
      bus.req_data[0]  = 32'h0000_0007;
      bus.req_data[1]  = 32'h0000_0008;
      repeat (2) @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.req_valid = '0;
      @(negedge clk);
      check("rst_we",    32'(bus.we), 32'h0);
      check("rst_wa",    32'(bus.wa), 32'h0);
      check("rst_wd",    bus.wd, 32'h0);
      check("rst_busy",  bus.busy, 32'h0);
      check("rst_ready", 32'(bus.req_ready), 32'h3);
      tick();
      @(negedge clk);
      check("rst_nopush_busy", bus.busy, 32'h0);
      check("rst_nopush_we",   32'(bus.we), 32'h0);

      // Single write r5 from requester 0; rr_ptr becomes 1.
      tick();
      expect_wr(5'd5, 32'hDEAD_BEEF);
      single_push(0, 5'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      check("single_busy_k1", bus.busy, 32'h0000_0020);
      check("single_we_k1",   32'(bus.we), 32'h0);
      tick();
      @(negedge clk);
      check("single_we_k2",   32'(bus.we), 32'h1);
      check("single_busy_k2", bus.busy, 32'h0000_0020);
      tick();
      @(negedge clk);
      check("single_we_k3",   32'(bus.we), 32'h0);
      check("single_busy_k3", bus.busy, 32'h0);

      // Register 0 from requester 1: consumed, never written; rr_ptr back to 0.
      tick();
      single_push(1, 5'd0, 32'h1234_5678);
      @(negedge clk);
      check("r0_busy_q",  bus.busy, 32'h0);
      tick();
      @(negedge clk);
      check("r0_we",      32'(bus.we), 32'h0);
      check("r0_busy_ws", bus.busy, 32'h0);
      check("r0_ready",   32'(bus.req_ready), 32'h3);

      // Contention: strict alternation starting with requester 0.
      tick();
      for (int i = 0; i < 4; i++) begin
         s_addr[0][i] = 5'(1 + i);
         s_data[0][i] = 32'h0000_0100 + 32'(i);
         s_addr[1][i] = 5'(9 + i);
         s_data[1][i] = 32'h0000_0200 + 32'(i);
      end
      s_cnt[0] = 4;
      s_cnt[1] = 4;
      for (int i = 0; i < 4; i++) begin
         expect_wr(5'(1 + i), 32'h0000_0100 + 32'(i));
         expect_wr(5'(9 + i), 32'h0000_0200 + 32'(i));
      end
      run_streams(-1, acc);
      repeat (8) tick();
      check("contention_drain", 32'(exp_q.size()), 32'h0);
      check("contention_idle_busy", bus.busy, 32'h0);

      // Register 0 from requester 0: no write, rr_ptr moves to 1.
      single_push(0, 5'd0, 32'hFFFF_0000);
      repeat (3) tick();

      // Backpressure: requester 1 wins first, so requester 0 fills after DEPTH accepts.
      for (int i = 0; i < 4; i++) begin
         s_addr[0][i] = 5'(16 + i);
         s_data[0][i] = 32'hA000_0000 + 32'(i);
      end
      for (int i = 0; i < 6; i++) begin
         s_addr[1][i] = 5'(20 + i);
         s_data[1][i] = 32'hB000_0000 + 32'(i);
      end
      s_cnt[0] = 4;
      s_cnt[1] = 6;
      for (int i = 0; i < 4; i++) begin
         expect_wr(5'(20 + i), 32'hB000_0000 + 32'(i));
         expect_wr(5'(16 + i), 32'hA000_0000 + 32'(i));
      end
      expect_wr(5'd24, 32'hB000_0004);
      expect_wr(5'd25, 32'hB000_0005);
      run_streams(0, acc);
      check("bp_accepts_before_drop", 32'(acc), 32'(DEPTH));
      repeat (8) tick();
      check("bp_drain", 32'(exp_q.size()), 32'h0);

      // Reset mid-operation with queues loaded; rr_ptr is 0 here.
      expect_wr(5'd26, 32'h0000_0C26);
      expect_wr(5'd29, 32'h0000_0C29);
      bus.req_valid   = '1;
      bus.req_addr[0] = 5'd26; bus.req_data[0] = 32'h0000_0C26;
      bus.req_addr[1] = 5'd29; bus.req_data[1] = 32'h0000_0C29;
      tick();
      bus.req_addr[0] = 5'd27; bus.req_data[0] = 32'h0000_0C27;
      bus.req_addr[1] = 5'd30; bus.req_data[1] = 32'h0000_0C30;
      tick();
      bus.req_addr[0] = 5'd28; bus.req_data[0] = 32'h0000_0C28;
      @(negedge clk);
      check("mid_ready_c2", 32'(bus.req_ready), 32'h1);
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("mid_busy_pre", bus.busy, 32'h7800_0000);
      check("mid_ready_c3", 32'(bus.req_ready), 32'h2);
      tick();
      reset         = 1'b0;
      bus.req_valid = '0;
      @(negedge clk);
      check("mid_rst_we",    32'(bus.we), 32'h0);
      check("mid_rst_wa",    32'(bus.wa), 32'h0);
      check("mid_rst_wd",    bus.wd, 32'h0);
      check("mid_rst_busy",  bus.busy, 32'h0);
      check("mid_rst_ready", 32'(bus.req_ready), 32'h3);
      repeat (6) tick();
      check("mid_no_late_writes", 32'(exp_q.size()), 32'h0);
      check("mid_idle_busy", bus.busy, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
